// File: rtl/iic_slave.sv
// I2C/SCCB target: oversampled SCL/SDA, START/STOP/bit decode, device-ID ACK
// and a simple register port (pointer, write strobe, read request).

module iic_slave_filt #(
  parameter int FILT_LEN = 3
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  localparam logic [3:0] CNT_LOAD = 4'(FILT_LEN - 1);

  logic [1:0] sync;
  logic [3:0] cnt;

  // Output flips once FILT_LEN consecutive synchronized samples disagree with it
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      cnt  <= CNT_LOAD;
      dout <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) begin
        cnt <= CNT_LOAD;
      end else if (cnt == 4'd0) begin
        dout <= sync[1];
        cnt  <= CNT_LOAD;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end
endmodule

// state   | meaning
// IDLE    | bus free, nothing addressed
// DEVID   | shifting in the device-ID byte
// DEVACK  | driving ACK for a matching ID
// ADDR    | shifting in the register pointer
// ADDRACK | driving ACK for the pointer byte
// WDATA   | shifting in a write data byte
// WACK    | driving ACK for a write byte
// RDATA   | shifting out a read byte
// RACK    | sampling the initiator's ACK/NACK
// IGNORE  | not addressed, wait for START/STOP
module iic_slave #(
  parameter logic [6:0] DEV_ID   = 7'h21,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    DEVID   = 4'd1,
    DEVACK  = 4'd2,
    ADDR    = 4'd3,
    ADDRACK = 4'd4,
    WDATA   = 4'd5,
    WACK    = 4'd6,
    RDATA   = 4'd7,
    RACK    = 4'd8,
    IGNORE  = 4'd9
  } state_t;

  state_t     state, state_nx;
  logic [3:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shreg, shreg_nx;
  logic [7:0] reg_addr_nx, reg_wdata_nx;
  logic       sda_oe_nx, reg_we_nx, reg_re_nx, busy_nx;
  logic       rd_load;
  logic       scl_f, sda_f, scl_q, sda_q;
  logic       scl_rise, scl_fall, bus_start, bus_stop;
  logic [7:0] byte_in;

  iic_slave_filt #(.FILT_LEN(FILT_LEN)) u_filt_scl (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .din     (scl_in),
    .dout    (scl_f)
  );

  iic_slave_filt #(.FILT_LEN(FILT_LEN)) u_filt_sda (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .din     (sda_in),
    .dout    (sda_f)
  );

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign bus_start = scl_f & scl_q & sda_q & ~sda_f;
  assign bus_stop  = scl_f & scl_q & ~sda_q & sda_f;
  assign byte_in   = {shreg[6:0], sda_f};

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      sda_oe    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      rd_load   <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      shreg     <= shreg_nx;
      sda_oe    <= sda_oe_nx;
      reg_addr  <= reg_addr_nx;
      reg_wdata <= reg_wdata_nx;
      reg_we    <= reg_we_nx;
      reg_re    <= reg_re_nx;
      busy      <= busy_nx;
      rd_load   <= reg_re;
      scl_q     <= scl_f;
      sda_q     <= sda_f;
    end
  end

  always_comb begin
    state_nx     = state;
    bit_cnt_nx   = bit_cnt;
    shreg_nx     = shreg;
    sda_oe_nx    = sda_oe;
    reg_addr_nx  = reg_addr;
    reg_wdata_nx = reg_wdata;
    reg_we_nx    = 1'b0;
    reg_re_nx    = 1'b0;
    busy_nx      = busy;

    if (bus_start) begin
      state_nx   = DEVID;
      bit_cnt_nx = 4'd0;
      sda_oe_nx  = 1'b0;
    end else if (bus_stop) begin
      state_nx   = IDLE;
      bit_cnt_nx = 4'd0;
      sda_oe_nx  = 1'b0;
      busy_nx    = 1'b0;
    end else begin
      // Read data arrives the cycle after reg_re; drive its MSB right away
      if (rd_load) begin
        shreg_nx  = reg_rdata;
        sda_oe_nx = ~reg_rdata[7];
      end
      case (state)
        DEVID: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shreg_nx   = byte_in;
            bit_cnt_nx = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (shreg[7:1] == DEV_ID) begin
              state_nx  = DEVACK;
              sda_oe_nx = 1'b1;
              busy_nx   = 1'b1;
            end else begin
              state_nx = IGNORE;
            end
          end
        end
        DEVACK: begin
          if (scl_fall) begin
            sda_oe_nx  = 1'b0;
            bit_cnt_nx = 4'd0;
            if (shreg[0]) begin
              state_nx  = RDATA;
              reg_re_nx = 1'b1;
            end else begin
              state_nx = ADDR;
            end
          end
        end
        ADDR: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shreg_nx   = byte_in;
            bit_cnt_nx = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) reg_addr_nx = byte_in;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            state_nx  = ADDRACK;
            sda_oe_nx = 1'b1;
          end
        end
        ADDRACK: begin
          if (scl_fall) begin
            state_nx   = WDATA;
            sda_oe_nx  = 1'b0;
            bit_cnt_nx = 4'd0;
          end
        end
        WDATA: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shreg_nx   = byte_in;
            bit_cnt_nx = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              reg_wdata_nx = byte_in;
              reg_we_nx    = 1'b1;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            state_nx  = WACK;
            sda_oe_nx = 1'b1;
          end
        end
        WACK: begin
          if (scl_fall) begin
            state_nx    = WDATA;
            sda_oe_nx   = 1'b0;
            bit_cnt_nx  = 4'd0;
            reg_addr_nx = reg_addr + 8'd1;
          end
        end
        RDATA: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            bit_cnt_nx = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            state_nx   = RACK;
            sda_oe_nx  = 1'b0;
            bit_cnt_nx = 4'd0;
          end else if (scl_fall && bit_cnt != 4'd0) begin
            shreg_nx  = {shreg[6:0], 1'b0};
            sda_oe_nx = ~shreg[6];
          end
        end
        RACK: begin
          // bit_cnt==1 marks "initiator ACKed, fetch next byte at the falling edge"
          if (scl_rise) begin
            reg_addr_nx = reg_addr + 8'd1;
            if (!sda_f) begin
              bit_cnt_nx = 4'd1;
            end else begin
              state_nx = IGNORE;
              busy_nx  = 1'b0;
            end
          end else if (scl_fall && bit_cnt == 4'd1) begin
            state_nx   = RDATA;
            reg_re_nx  = 1'b1;
            bit_cnt_nx = 4'd0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iic_slave.sv
// Directed bench for iic_slave: bit-banged initiator on a wired-AND SDA,
// small register-file model, hand-computed expectations.
`timescale 1ns/1ps

module tb_iic_slave;
  localparam int Q = 20;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic       scl_m   = 1'b1;
  logic       sda_m   = 1'b1;
  logic       scl_in, sda_in, sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy;

  int         n_chk = 0;
  int         n_err = 0;
  int         we_cnt = 0;
  int         re_cnt = 0;
  logic [7:0] we_addr[16];
  logic [7:0] we_data[16];
  logic [7:0] re_addr[16];

  always #5 clk_sys = ~clk_sys;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  iic_slave #(.DEV_ID(7'h21), .FILT_LEN(3)) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  function automatic logic [7:0] rd_val(input logic [7:0] a);
    case (a)
      8'h30:   rd_val = 8'h5A;
      8'h31:   rd_val = 8'h3C;
      default: rd_val = ~a;
    endcase
  endfunction

  always @(posedge clk_sys) begin
    if (reg_we) begin
      we_addr[we_cnt % 16] <= reg_addr;
      we_data[we_cnt % 16] <= reg_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (reg_re) begin
      re_addr[re_cnt % 16] <= reg_addr;
      re_cnt <= re_cnt + 1;
    end
    reg_rdata <= reg_re ? rd_val(reg_addr) : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(posedge clk_sys);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    sda_m = b; wq();
    scl_m = 1'b1;
    if (glitch) begin
      repeat (10) @(posedge clk_sys); #1;
      scl_m = 1'b0;
      @(posedge clk_sys); #1;
      scl_m = 1'b1;
      repeat (2*Q - 11) @(posedge clk_sys); #1;
    end else begin
      wq(); wq();
    end
    scl_m = 1'b0; wq();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    b = sda_in; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] d, input int gbit, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == gbit);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(mack, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         wb, rb;
    logic [7:0] ea[3];
    logic [7:0] ed[3];

    // reset state
    repeat (3) @(posedge clk_sys); #1;
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(reg_addr), 0);
    chk("rst_wdata", 32'(reg_wdata), 0);
    chk("rst_we_re", 32'({reg_we, reg_re}), 0);
    rst_n = 1'b1;
    wq();
    chk("rst_state", 32'(dut.state), 0);

    // 1: single write
    wb = we_cnt;
    i2c_start();
    write_byte(8'h42, -1, ack); chk("t1_ack_id", 32'(ack), 0);
    write_byte(8'h12, -1, ack); chk("t1_ack_addr", 32'(ack), 0);
    write_byte(8'h80, -1, ack); chk("t1_ack_data", 32'(ack), 0);
    chk("t1_busy", 32'(busy), 1);
    i2c_stop();
    chk("t1_busy_stop", 32'(busy), 0);
    chk("t1_we_cnt", 32'(we_cnt - wb), 1);
    chk("t1_we_addr", 32'(we_addr[wb % 16]), 32'h12);
    chk("t1_we_data", 32'(we_data[wb % 16]), 32'h80);
    chk("t1_addr", 32'(reg_addr), 32'h13);

    // 2: burst write wrapping the pointer
    wb = we_cnt;
    ea[0] = 8'hFE; ea[1] = 8'hFF; ea[2] = 8'h00;
    ed[0] = 8'hA1; ed[1] = 8'hB2; ed[2] = 8'hC3;
    i2c_start();
    write_byte(8'h42, -1, ack);
    write_byte(8'hFE, -1, ack);
    for (int i = 0; i < 3; i++) begin
      write_byte(ed[i], -1, ack);
      chk("t2_ack", 32'(ack), 0);
    end
    i2c_stop();
    chk("t2_we_cnt", 32'(we_cnt - wb), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_we_addr", 32'(we_addr[(wb + i) % 16]), 32'(ea[i]));
      chk("t2_we_data", 32'(we_data[(wb + i) % 16]), 32'(ed[i]));
    end
    chk("t2_addr", 32'(reg_addr), 32'h01);

    // 3: combined read with repeated START
    wb = we_cnt; rb = re_cnt;
    i2c_start();
    write_byte(8'h42, -1, ack);
    write_byte(8'h30, -1, ack);
    i2c_start();
    write_byte(8'h43, -1, ack); chk("t3_ack_rd", 32'(ack), 0);
    read_byte(rd, 1'b0); chk("t3_rd0", 32'(rd), 32'h5A);
    read_byte(rd, 1'b1); chk("t3_rd1", 32'(rd), 32'h3C);
    chk("t3_sda_rel", 32'(sda_oe), 0);
    chk("t3_state", 32'(dut.state), 9);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_re_cnt", 32'(re_cnt - rb), 2);
    chk("t3_re_a0", 32'(re_addr[rb % 16]), 32'h30);
    chk("t3_re_a1", 32'(re_addr[(rb + 1) % 16]), 32'h31);
    chk("t3_addr", 32'(reg_addr), 32'h32);
    chk("t3_no_we", 32'(we_cnt - wb), 0);
    i2c_stop();
    chk("t3_idle", 32'(dut.state), 0);

    // 4: foreign address is ignored
    wb = we_cnt; rb = re_cnt;
    i2c_start();
    write_byte(8'h44, -1, ack); chk("t4_nack", 32'(ack), 1);
    chk("t4_busy", 32'(busy), 0);
    write_byte(8'h10, -1, ack); chk("t4_nack2", 32'(ack), 1);
    chk("t4_state", 32'(dut.state), 9);
    i2c_stop();
    chk("t4_we_re", 32'((we_cnt - wb) + (re_cnt - rb)), 0);
    chk("t4_busy_stop", 32'(busy), 0);

    // 5: single-cycle SCL glitch inside a data byte
    wb = we_cnt;
    i2c_start();
    write_byte(8'h42, -1, ack);
    write_byte(8'h50, 6, ack);  chk("t5_ack_addr", 32'(ack), 0);
    write_byte(8'h77, 3, ack);  chk("t5_ack_data", 32'(ack), 0);
    i2c_stop();
    chk("t5_we_cnt", 32'(we_cnt - wb), 1);
    chk("t5_we_addr", 32'(we_addr[wb % 16]), 32'h50);
    chk("t5_we_data", 32'(we_data[wb % 16]), 32'h77);
    chk("t5_addr", 32'(reg_addr), 32'h51);

    // 6a: STOP after 4 bits of a data byte
    wb = we_cnt;
    i2c_start();
    write_byte(8'h42, -1, ack);
    write_byte(8'h60, -1, ack);
    for (int i = 0; i < 4; i++) write_bit(1'b1, 1'b0);
    i2c_stop();
    chk("t6a_no_we", 32'(we_cnt - wb), 0);
    chk("t6a_state", 32'(dut.state), 0);
    chk("t6a_addr", 32'(reg_addr), 32'h60);

    // 6b: asynchronous reset while driving a read byte
    i2c_start();
    write_byte(8'h42, -1, ack);
    write_byte(8'h30, -1, ack);
    i2c_start();
    write_byte(8'h43, -1, ack);
    chk("t6b_driving", 32'(sda_oe), 1);
    chk("t6b_rdata", 32'(dut.state), 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6b_sda_oe", 32'(sda_oe), 0);
    chk("t6b_busy", 32'(busy), 0);
    chk("t6b_addr", 32'(reg_addr), 0);
    chk("t6b_wdata", 32'(reg_wdata), 0);
    chk("t6b_we_re", 32'({reg_we, reg_re}), 0);
    chk("t6b_state", 32'(dut.state), 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wq();
    rst_n = 1'b1;
    wq();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/iic_slave.md
Name: iic_slave

Overview:
- I2C/SCCB responder (target): the far end of the camera-side 2-wire bus mastered by the existing iic_inf initiator.
- Fully synchronous to clk_sys: oversamples SCL/SDA, decodes START/STOP/bits, ACKs its device ID.
- Exposes a simple register port so a local register file can be written and read over the bus.
- Used as a bus model/target in simulation and as a configuration slave in FPGA-to-FPGA links.

Parameters:
DEV_ID, 7'h21, 7-bit target address (0x42 write / 0x43 read in 8-bit form).
FILT_LEN, 3, consecutive identical samples required before a filtered SCL/SDA level changes (1..15).

Ports:
clk_sys  input  1  system clock, at least 20x SCL rate.
rst_n  input  1  asynchronous active-low reset.
scl_in  input  1  bus SCL level, asynchronous.
sda_in  input  1  bus SDA level, asynchronous.
sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
reg_addr  output  8  register pointer.
reg_wdata  output  8  write data, valid with reg_we.
reg_we  output  1  one-cycle write strobe.
reg_re  output  1  one-cycle read request.
reg_rdata  input  8  read data, sampled exactly 1 cycle after reg_re.
busy  output  1  high from an addressed START (ID match) to STOP or NACK.

Behaviour:
- Reset: sda_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, state IDLE, filtered scl/sda=1.
- Input path: 2-flop synchronizer, then a filter whose output changes only after FILT_LEN equal samples. Pin-to-internal latency is 2+FILT_LEN cycles. Edges are detected on the filtered signals.
- Bus conditions:
  - START: filtered SDA falls while filtered SCL is high.
  - STOP: filtered SDA rises while filtered SCL is high.
- Bit timing:
  - Data is sampled on SCL rising edges.
  - sda_oe changes only one cycle after an SCL falling edge, never while SCL is high.
- States: IDLE, DEVID, DEVACK, ADDR, ADDRACK, WDATA, WACK, RDATA, RACK, IGNORE.
- Transitions:
  - START (any state, including repeated START) -> DEVID. Bit counter is cleared, sda_oe=0, reg_addr is kept.
  - STOP (any state) -> IDLE, sda_oe=0, busy=0.
  - DEVID, after 8 bits:
    - bits[7:1]==DEV_ID -> DEVACK. sda_oe=1 after the 8th falling edge; busy=1.
    - Otherwise -> IGNORE, SDA untouched.
  - DEVACK, at the 9th falling edge: release SDA.
    - R/W=0 -> ADDR.
    - R/W=1 -> pulse reg_re, latch reg_rdata next cycle into the shift register, drive its MSB -> RDATA.
  - ADDR, 8 bits -> reg_addr loaded at the 8th rising edge; ACK -> ADDRACK -> WDATA.
  - WDATA, 8 bits -> at the 8th rising edge, reg_wdata set and reg_we pulses one cycle with the current reg_addr; ACK (WACK) follows.
    - At the WACK falling edge, reg_addr increments; loop to WDATA.
  - RDATA: drive sda_oe = ~bit (MSB first), updating after each falling edge. After 8 bits, release -> RACK.
  - RACK, sample at the rising edge:
    - Master ACK (0) -> reg_addr+1, then at the falling edge reg_re/latch next byte -> RDATA.
    - NACK (1) -> IGNORE; reg_addr still increments, busy=0.
  - IGNORE: no driving; wait for START/STOP.
- reg_addr wraps 0xFF -> 0x00.
- A START or STOP inside a byte aborts it: no reg_we for the partial byte, and the pointer is unchanged.
- Clock stretching is never performed.
- Simultaneous START detection and a bit edge: START wins.

Test Plan:
1. Write 0x42, 0x12, 0x80, STOP -> ACK low on all 3 bytes; single reg_we with reg_addr=0x12, reg_wdata=0x80; busy falls at STOP; final reg_addr=0x13.
2. Burst write 0x42, 0xFE, 0xA1, 0xB2, 0xC3 -> three reg_we pulses at addr 0xFE, 0xFF, 0x00 (wrap); final reg_addr=0x01.
3. Combined read: 0x42, 0x30, repeated START, 0x43, then master reads 2 bytes (ACK, then NACK), with rdata 0x5A@0x30 and 0x3C@0x31:
   - slave shifts out 0x5A then 0x3C;
   - reg_re pulses at 0x30 and 0x31;
   - SDA released after the NACK;
   - state IGNORE.
4. Address 0x44 -> no sda_oe on the ACK bit (NACK seen by master), no reg_we/reg_re, busy stays 0 until STOP.
5. Glitch: 1-cycle low pulse on SCL (< FILT_LEN) during a byte -> no extra bit shifted; the byte decodes correctly.
6. Robustness:
   - STOP after 4 bits of a data byte -> no reg_we; IDLE.
   - Separately, assert rst_n low during RDATA -> sda_oe=0 and all outputs at reset values immediately (asynchronous).
